// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
//   fetch_state_e : fetch FSM states (boot, running, parked on a fault)
//   fetch_entry_t : one buffered fetch result {pc, inst, fault}
//   INST_NOP      : instruction substituted for a faulting fetch
//   fetch_fault() : misaligned / out-of-range test for a byte address
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // A fetch faults when the address is not word aligned or its word index
    // lies beyond the end of instruction memory.
    function automatic logic fetch_fault(input logic [31:0] addr,
                                         input int unsigned mem_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry in-order buffer of fetch results between fetch and decode.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, entry   : write one entry at the tail
//   pop           : remove the head (ignored when empty)
//   flush         : drop all entries; wins over push/pop
//   head          : registered head entry
//   count         : number of stored entries (0..2)
// Push and pop may occur together at any occupancy; the caller never pushes
// into a full buffer without popping in the same cycle.
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign head   = mem[rd_ptr];

    // NOTE: storage is reset as well as the pointers so the head outputs read
    // as zero straight out of reset; sequential state uses <= only so every
    // register samples the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator. Owns the PC, drives it to a combinational
// instruction memory, buffers each returned word with its PC and presents it
// to decode over a valid/ready handshake.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   imem_addr_o     : byte address to imem (the PC register)
//   imem_inst_i     : word returned for imem_addr_o in the same cycle
//   redirect_i      : load redirect_pc_i into the PC and flush the buffer
//   redirect_pc_i   : redirect target byte address
//   if_valid_o      : buffer head holds an entry
//   if_ready_i      : decode accepts the head
//   if_inst_o/pc_o  : head instruction and its PC
//   if_fault_o      : head is a fetch fault (instruction is a NOP)
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 2048
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        if_fault_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push;
    logic         fire;
    logic         pc_fault;
    fetch_entry_t new_entry;
    fetch_entry_t head;
    logic [1:0]   count;

    assign fire     = if_valid_o && if_ready_i;
    assign pc_fault = fetch_fault(pc_q, MEM_WORDS);

    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        push      = 1'b0;
        new_entry = '{pc: pc_q, inst: imem_inst_i, fault: 1'b0};
        if (pc_fault) begin
            new_entry.inst  = INST_NOP;
            new_entry.fault = 1'b1;
        end

        if (redirect_i) begin
            // Redirect overrides any enqueue; the buffer is flushed below.
            pc_d = redirect_pc_i;
            unique case (state_q)
                S_BOOT:  state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                S_FAULT: if (!fetch_fault(redirect_pc_i, MEM_WORDS)) state_d = S_RUN;
                default: state_d = S_BOOT;
            endcase
        end else begin
            unique case (state_q)
                S_BOOT:  state_d = S_RUN;
                S_RUN: begin
                    // A full buffer still accepts a new entry when its head
                    // leaves in the same cycle.
                    if ((count != 2'd2) || fire) begin
                        push = 1'b1;
                        if (pc_fault) begin
                            // Park on the faulting PC so only one fault entry is made.
                            state_d = S_FAULT;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifetch_fifo u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (fire),
        .flush  (redirect_i),
        .entry  (new_entry),
        .head   (head),
        .count  (count)
    );

    assign imem_addr_o = pc_q;
    assign if_valid_o  = (count != 2'd0);
    assign if_inst_o   = head.inst;
    assign if_pc_o     = head.pc;
    assign if_fault_o  = head.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. Expected fetch results are queued as
// each scenario is set up and compared as decode accepts them.
module tb_ifetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_fault_o;

    ifetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_addr_o   (imem_addr_o),
        .imem_inst_i   (imem_inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o),
        .if_fault_o    (if_fault_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational instruction memory: word = address ^ A5A5_0000.
    assign imem_inst_i = imem_addr_o ^ 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Advance to just after the next rising edge: outputs are sampled and
    // inputs changed here, well away from the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_ok(input logic [31:0] pc);
        sb.push_back('{pc: pc, inst: pc ^ 32'hA5A5_0000, fault: 1'b0});
    endtask

    task automatic expect_fault(input logic [31:0] pc);
        sb.push_back('{pc: pc, inst: 32'h0000_0013, fault: 1'b1});
    endtask

    // Called at a sample point where the head is about to be accepted.
    task automatic take(input string name);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: head pc=%h valid=%b but no entry expected", name, if_pc_o, if_valid_o);
        end else begin
            e = sb.pop_front();
            if (!(if_valid_o === 1'b1 && if_pc_o === e.pc && if_inst_o === e.inst && if_fault_o === e.fault)) begin
                bad++;
                $display("FAIL %s: got v=%b pc=%h inst=%h f=%b want v=1 pc=%h inst=%h f=%b",
                         name, if_valid_o, if_pc_o, if_inst_o, if_fault_o, e.pc, e.inst, e.fault);
            end
        end
    endtask

    task automatic expect_idle(input string name);
        total++;
        if (if_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s: if_valid_o=%b pc=%h want valid=0", name, if_valid_o, if_pc_o);
        end
    endtask

    task automatic apply_reset(input logic ready);
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        if_ready_i    = ready;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        total++;
        if ({imem_addr_o, if_valid_o, if_inst_o, if_pc_o, if_fault_o} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: addr=%h v=%b inst=%h pc=%h f=%b want all zero",
                     imem_addr_o, if_valid_o, if_inst_o, if_pc_o, if_fault_o);
        end
        step();
        expect_idle("boot_no_enqueue");
    endtask

    task automatic test_stream();
        expect_ok(32'h0);
        expect_ok(32'h4);
        expect_ok(32'h8);
        step();
        for (int i = 0; i < 3; i++) begin
            take($sformatf("stream_%0d", i));
            step();
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (!(imem_addr_o === 32'h8 && if_valid_o === 1'b1 && if_pc_o === 32'h0 &&
                  if_inst_o === 32'hA5A5_0000 && if_fault_o === 1'b0)) begin
                bad++;
                $display("FAIL stall_hold_%0d: addr=%h v=%b pc=%h inst=%h want addr=8 v=1 pc=0 inst=a5a50000",
                         i, imem_addr_o, if_valid_o, if_pc_o, if_inst_o);
            end
        end
        if_ready_i = 1'b1;
        expect_ok(32'h0);
        expect_ok(32'h4);
        expect_ok(32'h8);
        for (int i = 0; i < 3; i++) begin
            take($sformatf("drain_%0d", i));
            step();
        end
    endtask

    // Entering with the buffer full (head PC 0xC) and ready=1.
    task automatic test_redirect_full();
        expect_ok(32'hC);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        take("redirect_fire_head");
        step();
        redirect_i = 1'b0;
        expect_idle("redirect_bubble");
        step();
        expect_ok(32'h40);
        expect_ok(32'h44);
        take("redirect_target_0");
        step();
        take("redirect_target_1");
    endtask

    task automatic test_misaligned();
        if_ready_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h42;
        step();
        redirect_i = 1'b0;
        if_ready_i = 1'b1;
        expect_idle("misalign_bubble");
        step();
        expect_fault(32'h42);
        take("misalign_fault");
        for (int i = 0; i < 4; i++) begin
            step();
            expect_idle($sformatf("fault_parked_%0d", i));
            total++;
            if (imem_addr_o !== 32'h42) begin
                bad++;
                $display("FAIL fault_pc_hold_%0d: addr=%h want 00000042", i, imem_addr_o);
            end
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        step();
        redirect_i = 1'b0;
        expect_idle("recover_bubble");
        step();
        expect_ok(32'h80);
        expect_ok(32'h84);
        take("recover_0");
        step();
        take("recover_1");
    endtask

    task automatic test_mem_end();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h1FF8;
        step();
        redirect_i = 1'b0;
        step();
        expect_ok(32'h1FF8);
        expect_ok(32'h1FFC);
        expect_fault(32'h2000);
        for (int i = 0; i < 3; i++) begin
            take($sformatf("mem_end_%0d", i));
            step();
        end
        expect_idle("mem_end_parked");
    endtask

    task automatic test_reset_midstream();
        if_ready_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        step();
        step();
        step();
        total++;
        if (!(if_valid_o === 1'b1 && if_pc_o === 32'h100 && imem_addr_o === 32'h108)) begin
            bad++;
            $display("FAIL midreset_full: v=%b pc=%h addr=%h want v=1 pc=100 addr=108",
                     if_valid_o, if_pc_o, imem_addr_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({imem_addr_o, if_valid_o, if_inst_o, if_pc_o, if_fault_o} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_async: addr=%h v=%b inst=%h pc=%h f=%b want all zero",
                     imem_addr_o, if_valid_o, if_inst_o, if_pc_o, if_fault_o);
        end
        step();
        rst_ni     = 1'b1;
        if_ready_i = 1'b1;
        step();
        expect_idle("midreset_boot");
        step();
        expect_ok(32'h0);
        expect_ok(32'h4);
        take("restart_0");
        step();
        take("restart_1");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_mem_end();
        test_reset_midstream();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: %0d entries never delivered", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
